// File: rtl/dct_pkg.sv
// dct_pkg: shared block size, counter-width helper and block tag type for the DCT transposer
package dct_pkg;
    localparam int DctN = 8;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    typedef struct packed {
        logic sof;
        logic eol;
    } tag_t;
endpackage

// File: rtl/dct_block_transpose_bank.sv
// transpose_bank: one NxN sample store, row written per beat, column read combinationally
// Ports: clk_i/rst_i clock and async high reset (clears storage); we_i/row_i/data_i row write;
//        col_i/data_o column read, data_o[r] = mem[r][col_i]
module transpose_bank
    import dct_pkg::*;
#(
    parameter int N         = DctN,
    parameter int DataWidth = 14,
    localparam int CntW     = cnt_w(N)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [CntW-1:0]              row_i,
    input  logic [0:N-1][DataWidth-1:0]  data_i,
    input  logic [CntW-1:0]              col_i,
    output logic [0:N-1][DataWidth-1:0]  data_o
);
    logic [0:N-1][0:N-1][DataWidth-1:0] r_mem;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) r_mem <= '0;
        else if (we_i) r_mem[row_i] <= data_i;
    for (genvar r = 0; r < N; r++) begin : g_col
        assign data_o[r] = r_mem[r][col_i];
    end
endmodule

// File: rtl/dct_block_transpose.sv
// dct_block_transpose: NxN block transposer with ping-pong banks (rows in, columns out)
// Ports: clk_i/rst_i clock and async high reset; s_* row-vector input stream with sof/eol tags;
//        m_* column-vector output stream with sof on column 0 and eol on column N-1;
//        err_o sticky flag for sof seen on a row other than 0
module dct_block_transpose
    import dct_pkg::*;
#(
    parameter int N         = DctN,
    parameter int DataWidth = 14,
    parameter int Banks     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic                         s_sof_i,
    input  logic                         s_eol_i,
    input  logic [0:N-1][DataWidth-1:0]  s_data_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic                         m_sof_o,
    output logic                         m_eol_o,
    output logic [0:N-1][DataWidth-1:0]  m_data_o,
    output logic                         err_o
);
    localparam int CntW = cnt_w(N);
    localparam logic [CntW-1:0] Last = CntW'(N - 1);

    logic [Banks-1:0]            r_full, w_full_next;
    tag_t [Banks-1:0]            r_tag;
    logic                        r_wr_bank, r_rd_bank, w_wr_bank_next, w_rd_bank_next;
    logic [CntW-1:0]             r_wr_row, r_rd_col;
    logic                        r_sof_acc, r_eol_acc, r_s_ready, r_m_valid, r_err;
    logic                        w_acc, w_rd, w_last_wr, w_last_rd;
    logic [0:N-1][DataWidth-1:0] w_col [Banks];

    assign w_acc     = s_valid_i & r_s_ready;
    assign w_rd      = r_m_valid & m_ready_i;
    assign w_last_wr = w_acc & (r_wr_row == Last);
    assign w_last_rd = w_rd & (r_rd_col == Last);

    // Write and read never complete on the same bank in one cycle, so both updates compose.
    always_comb begin
        w_full_next = r_full;
        if (w_last_wr) w_full_next[r_wr_bank] = 1'b1;
        if (w_last_rd) w_full_next[r_rd_bank] = 1'b0;
        w_wr_bank_next = w_last_wr ? ((Banks == 2) ? ~r_wr_bank : 1'b0) : r_wr_bank;
        w_rd_bank_next = w_last_rd ? ((Banks == 2) ? ~r_rd_bank : 1'b0) : r_rd_bank;
    end

    // Handshake flags are registered from next-state so s_ready_o never sees m_ready_i combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_full    <= '0;
            r_tag     <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_row  <= '0;
            r_rd_col  <= '0;
            r_sof_acc <= 1'b0;
            r_eol_acc <= 1'b0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_full    <= w_full_next;
            r_wr_bank <= w_wr_bank_next;
            r_rd_bank <= w_rd_bank_next;
            r_s_ready <= !w_full_next[w_wr_bank_next];
            r_m_valid <= w_full_next[w_rd_bank_next];
            if (w_acc) begin
                r_wr_row  <= w_last_wr ? '0 : r_wr_row + 1'b1;
                r_sof_acc <= (r_wr_row == '0) ? s_sof_i : r_sof_acc;
                r_eol_acc <= ((r_wr_row == '0) ? 1'b0 : r_eol_acc) | s_eol_i;
                if (s_sof_i && r_wr_row != '0) r_err <= 1'b1;
            end
            if (w_last_wr) r_tag[r_wr_bank] <= {r_sof_acc, r_eol_acc | s_eol_i};
            if (w_rd) r_rd_col <= w_last_rd ? '0 : r_rd_col + 1'b1;
        end
    end

    for (genvar g = 0; g < Banks; g++) begin : g_bank
        transpose_bank #(.N(N), .DataWidth(DataWidth)) u_bank (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .we_i   (w_acc && r_wr_bank == 1'(g)),
            .row_i  (r_wr_row),
            .data_i (s_data_i),
            .col_i  (r_rd_col),
            .data_o (w_col[g])
        );
    end

    assign s_ready_o = r_s_ready;
    assign m_valid_o = r_m_valid;
    assign m_data_o  = w_col[r_rd_bank];
    assign m_sof_o   = r_tag[r_rd_bank].sof & (r_rd_col == '0);
    assign m_eol_o   = r_tag[r_rd_bank].eol & (r_rd_col == Last);
    assign err_o     = r_err;
endmodule

// File: tb/tb_dct_block_transpose.sv
// tb_dct_block_transpose: directed bench with a queue-based transpose model checked every cycle
module tb_dct_block_transpose;
    localparam int N = 8;
    localparam int DW = 14;
    localparam int BANKS = 2;

    logic clk_i = 1'b0;
    logic rst_i, s_valid_i, s_ready_o, s_sof_i, s_eol_i;
    logic m_valid_o, m_ready_i, m_sof_o, m_eol_o, err_o;
    logic [0:N-1][DW-1:0] s_data_i, m_data_o;

    dct_block_transpose #(.N(N), .DataWidth(DW), .Banks(BANKS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_sof_i(s_sof_i), .s_eol_i(s_eol_i), .s_data_i(s_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_sof_o(m_sof_o),
        .m_eol_o(m_eol_o), .m_data_o(m_data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [0:N-1][DW-1:0] d;
        logic sof;
        logic eol;
    } beat_t;

    beat_t q[$];
    logic [DW-1:0] blk [N][N];
    int total = 0, bad = 0;
    int m_row = 0, cyc = 0, out_cnt = 0, sof_cnt = 0, eol_cnt = 0, rdy_drop = 0;
    int first_in_cyc = 0, last_out_cyc = 0, rdy_mode = 0;
    logic m_sof = 0, m_eol = 0, exp_err = 0, settle = 1, prev_stall = 0, mark = 0;
    logic [127:0] prev_word;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model and compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            q.delete();
            m_row = 0; m_sof = 0; m_eol = 0; exp_err = 0; settle = 1; prev_stall = 0;
        end else begin
            int nblk;
            beat_t b;
            nblk = (q.size() + N - 1) / N;
            chk("s_ready", 128'(s_ready_o), settle ? 128'(0) : 128'(nblk < BANKS));
            chk("m_valid", 128'(m_valid_o), 128'(q.size() != 0));
            chk("err", 128'(err_o), 128'(exp_err));
            if (prev_stall) chk("stall_hold", 128'({m_valid_o, m_sof_o, m_eol_o, m_data_o}), prev_word);
            if (m_valid_o && q.size() != 0) begin
                chk("m_data", 128'(m_data_o), 128'(q[0].d));
                chk("m_sof", 128'(m_sof_o), 128'(q[0].sof));
                chk("m_eol", 128'(m_eol_o), 128'(q[0].eol));
            end
            if (m_valid_o && m_ready_i) begin
                if (q.size() != 0) void'(q.pop_front());
                out_cnt++;
                if (m_sof_o) sof_cnt++;
                if (m_eol_o) eol_cnt++;
                last_out_cyc = cyc;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_word = 128'({m_valid_o, m_sof_o, m_eol_o, m_data_o});
            if (s_valid_i && !s_ready_o) rdy_drop++;
            if (s_valid_i && s_ready_o) begin
                if (mark) begin first_in_cyc = cyc; mark = 0; end
                for (int c = 0; c < N; c++) blk[m_row][c] = s_data_i[c];
                if (m_row == 0) begin
                    m_sof = s_sof_i; m_eol = s_eol_i;
                end else begin
                    m_eol = m_eol | s_eol_i;
                    if (s_sof_i) exp_err = 1;
                end
                if (m_row == N - 1) begin
                    for (int c = 0; c < N; c++) begin
                        for (int r = 0; r < N; r++) b.d[r] = blk[r][c];
                        b.sof = m_sof && c == 0;
                        b.eol = m_eol && c == N - 1;
                        q.push_back(b);
                    end
                    m_row = 0;
                end else m_row++;
            end
            settle = 0;
        end
        cyc++;
    end

    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            m_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic send_block(input int base, input int nrows, input int sof_row, input int eol_row);
        for (int r = 0; r < nrows; r++) begin
            logic acc;
            s_valid_i = 1'b1;
            s_sof_i = (r == sof_row);
            s_eol_i = (r == eol_row);
            for (int c = 0; c < N; c++) s_data_i[c] = DW'(base + 16 * r + c);
            acc = 0;
            for (int k = 0; k < 300 && !acc; k++) begin
                @(negedge clk_i); acc = s_ready_o;
                @(posedge clk_i); #1;
            end
            chk("send_accept", 128'(acc), 128'(1));
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 600 && q.size() != 0; k++) begin
            @(posedge clk_i); #1;
        end
        chk("drain", 128'(q.size()), 128'(0));
        repeat (3) begin @(posedge clk_i); #1; end
    endtask

    task automatic clear_counts();
        out_cnt = 0; sof_cnt = 0; eol_cnt = 0; rdy_drop = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, 128'(m_valid_o), 128'(0));
        chk({tag, "_s_ready"}, 128'(s_ready_o), 128'(0));
        chk({tag, "_err"}, 128'(err_o), 128'(0));
        chk({tag, "_tags"}, 128'({m_sof_o, m_eol_o}), 128'(0));
        chk({tag, "_data"}, 128'(m_data_o), 128'(0));
    endtask

    initial begin
        rst_i = 1'b1; s_valid_i = 0; s_sof_i = 0; s_eol_i = 0; s_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // single block with hand-computed samples 16r+c
        clear_counts();
        send_block(0, N, 0, -1);
        s_valid_i = 0;
        chk("lat_valid", 128'(m_valid_o), 128'(1));
        chk("col0_lane3", 128'(m_data_o[3]), 128'(48));
        chk("col0_lane7", 128'(m_data_o[7]), 128'(112));
        chk("col0_sof", 128'(m_sof_o), 128'(1));
        @(posedge clk_i); #1;
        chk("col1_lane2", 128'(m_data_o[2]), 128'(33));
        chk("col1_sof", 128'(m_sof_o), 128'(0));
        repeat (6) begin @(posedge clk_i); #1; end
        chk("col7_lane0", 128'(m_data_o[0]), 128'(7));
        chk("col7_lane7", 128'(m_data_o[7]), 128'(119));
        wait_drain();
        chk("single_beats", 128'(out_cnt), 128'(8));
        chk("single_sof_cnt", 128'(sof_cnt), 128'(1));

        // four blocks back-to-back, no backpressure
        clear_counts();
        mark = 1;
        for (int b = 0; b < 4; b++) send_block(1000 * (b + 1), N, -1, -1);
        s_valid_i = 0;
        wait_drain();
        chk("b2b_beats", 128'(out_cnt), 128'(32));
        chk("b2b_ready_drop", 128'(rdy_drop), 128'(0));
        chk("b2b_span", 128'(last_out_cyc - first_in_cyc), 128'(39));

        // random output backpressure
        clear_counts();
        rdy_mode = 1;
        for (int b = 0; b < 4; b++) send_block(3000 + 500 * b, N, -1, -1);
        s_valid_i = 0;
        wait_drain();
        rdy_mode = 0;
        chk("bp_beats", 128'(out_cnt), 128'(32));

        // framing tags: sof on block 0 row 0, eol on block 2 row 7
        clear_counts();
        send_block(100, N, 0, -1);
        send_block(200, N, -1, -1);
        send_block(300, N, -1, N - 1);
        s_valid_i = 0;
        wait_drain();
        chk("tag_sof_cnt", 128'(sof_cnt), 128'(1));
        chk("tag_eol_cnt", 128'(eol_cnt), 128'(1));
        chk("tag_err", 128'(err_o), 128'(0));

        // misplaced sof on row 3
        clear_counts();
        send_block(400, N, 3, -1);
        s_valid_i = 0;
        wait_drain();
        chk("missof_err", 128'(err_o), 128'(1));
        chk("missof_beats", 128'(out_cnt), 128'(8));

        // reset with one full block parked and a partial block in flight
        rdy_mode = 2;
        send_block(500, N, 0, -1);
        send_block(600, 5, -1, -1);
        s_valid_i = 0;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        rdy_mode = 0;
        clear_counts();
        send_block(700, N, 0, N - 1);
        s_valid_i = 0;
        wait_drain();
        chk("postrst_beats", 128'(out_cnt), 128'(8));
        chk("postrst_sof_cnt", 128'(sof_cnt), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
